// File: rtl/etapa_id_ex.sv
// ID/EX pipeline register with load-use / branch-in-ID stall control; 1-cycle ID->EX latency.
// detener freezes PC and IF/ID while bubbles are inserted; congelar holds all state, limpiar flushes.
module etapa_id_ex #(
  parameter int ANCHO_DATO = 32,
  parameter int ANCHO_CTRL = 8,
  parameter int ANCHO_REG  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ANCHO_REG-1:0]  RsD,
  input  logic [ANCHO_REG-1:0]  RtD,
  input  logic [ANCHO_REG-1:0]  RdD,
  input  logic                  UsaRsD,
  input  logic                  UsaRtD,
  input  logic                  EscRegD,
  input  logic                  LeeMemD,
  input  logic                  EsBranchD,
  input  logic [ANCHO_CTRL-1:0] CtrlD,
  input  logic [ANCHO_DATO-1:0] A_D,
  input  logic [ANCHO_DATO-1:0] B_D,
  input  logic [ANCHO_DATO-1:0] Inm_D,
  input  logic [ANCHO_REG-1:0]  RdMem,
  input  logic                  EscMem,
  input  logic                  congelar,
  input  logic                  limpiar,
  output logic [ANCHO_REG-1:0]  Rs,
  output logic [ANCHO_REG-1:0]  Rt,
  output logic [ANCHO_REG-1:0]  RdEx,
  output logic                  EscMemEx,
  output logic                  LeeMemEx,
  output logic [ANCHO_CTRL-1:0] CtrlEx,
  output logic [ANCHO_DATO-1:0] A_Ex,
  output logic [ANCHO_DATO-1:0] B_Ex,
  output logic [ANCHO_DATO-1:0] Inm_Ex,
  output logic                  detener
);

  logic [1:0] r_contador;
  logic [1:0] w_n;
  logic       w_dep_ex;
  logic       w_dep_mem;
  logic       w_detener;

  function automatic logic dep(input logic [ANCHO_REG-1:0] rd, input logic w,
                               input logic [ANCHO_REG-1:0] rs, input logic usa_rs,
                               input logic [ANCHO_REG-1:0] rt, input logic usa_rt);
    return w && (rd != '0) && ((usa_rs && rd == rs) || (usa_rt && rd == rt));
  endfunction

  always_comb begin
    w_dep_ex  = dep(RdEx, EscMemEx, RsD, UsaRsD, RtD, UsaRtD);
    w_dep_mem = dep(RdMem, EscMem, RsD, UsaRsD, RtD, UsaRtD);
    w_n       = 2'd0;
    // Detection runs only between stalls so an ongoing stall cannot be re-extended.
    if (r_contador == 2'd0) begin
      if (EsBranchD && LeeMemEx && w_dep_ex)       w_n = 2'd2;
      else if (EsBranchD && w_dep_mem)             w_n = 2'd1;
      else if (!EsBranchD && LeeMemEx && w_dep_ex) w_n = 2'd1;
    end
    w_detener = rst_n && ((r_contador != 2'd0) || (w_n != 2'd0));
  end

  assign detener = w_detener;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_contador <= 2'd0;
      Rs         <= '0;
      Rt         <= '0;
      RdEx       <= '0;
      EscMemEx   <= 1'b0;
      LeeMemEx   <= 1'b0;
      CtrlEx     <= '0;
      A_Ex       <= '0;
      B_Ex       <= '0;
      Inm_Ex     <= '0;
    end else if (limpiar || (!congelar && w_detener)) begin
      if (limpiar)                 r_contador <= 2'd0;
      else if (r_contador == 2'd0) r_contador <= w_n - 2'd1;
      else                         r_contador <= r_contador - 2'd1;
      Rs       <= '0;
      Rt       <= '0;
      RdEx     <= '0;
      EscMemEx <= 1'b0;
      LeeMemEx <= 1'b0;
      CtrlEx   <= '0;
      A_Ex     <= '0;
      B_Ex     <= '0;
      Inm_Ex   <= '0;
    end else if (!congelar) begin
      Rs       <= RsD;
      Rt       <= RtD;
      RdEx     <= RdD;
      EscMemEx <= EscRegD;
      LeeMemEx <= LeeMemD;
      CtrlEx   <= CtrlD;
      A_Ex     <= A_D;
      B_Ex     <= B_D;
      Inm_Ex   <= Inm_D;
    end
  end

endmodule

// File: tb/tb_etapa_id_ex.sv
// Bench for etapa_id_ex: directed hazard scenarios followed by random traffic against a behavioural model.
module tb_etapa_id_ex;
  localparam int AD = 32;
  localparam int AC = 8;
  localparam int AR = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AR-1:0] RsD, RtD, RdD, RdMem;
  logic UsaRsD, UsaRtD, EscRegD, LeeMemD, EsBranchD, EscMem, congelar, limpiar;
  logic [AC-1:0] CtrlD;
  logic [AD-1:0] A_D, B_D, Inm_D;
  logic [AR-1:0] Rs, Rt, RdEx;
  logic EscMemEx, LeeMemEx, detener;
  logic [AC-1:0] CtrlEx;
  logic [AD-1:0] A_Ex, B_Ex, Inm_Ex;

  etapa_id_ex #(.ANCHO_DATO(AD), .ANCHO_CTRL(AC), .ANCHO_REG(AR)) dut (
    .clk(clk), .rst_n(rst_n), .RsD(RsD), .RtD(RtD), .RdD(RdD), .UsaRsD(UsaRsD), .UsaRtD(UsaRtD),
    .EscRegD(EscRegD), .LeeMemD(LeeMemD), .EsBranchD(EsBranchD), .CtrlD(CtrlD), .A_D(A_D),
    .B_D(B_D), .Inm_D(Inm_D), .RdMem(RdMem), .EscMem(EscMem), .congelar(congelar),
    .limpiar(limpiar), .Rs(Rs), .Rt(Rt), .RdEx(RdEx), .EscMemEx(EscMemEx), .LeeMemEx(LeeMemEx),
    .CtrlEx(CtrlEx), .A_Ex(A_Ex), .B_Ex(B_Ex), .Inm_Ex(Inm_Ex), .detener(detener)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model of the instruction sitting in EX, plus stall cycles still owed after the current one.
  logic [AR-1:0] m_rs, m_rt, m_rd;
  logic m_esc, m_lee;
  logic [AC-1:0] m_ctrl;
  logic [AD-1:0] m_a, m_b, m_inm;
  int m_left;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit depends(input logic [AR-1:0] rd, input logic w);
    if (!w || rd == 0) return 0;
    return (UsaRsD && rd == RsD) || (UsaRtD && rd == RtD);
  endfunction

  function automatic int stalls_needed();
    if (m_left != 0) return 0;
    if (EsBranchD && m_lee && depends(m_rd, m_esc)) return 2;
    if (EsBranchD && depends(RdMem, EscMem)) return 1;
    if (!EsBranchD && m_lee && depends(m_rd, m_esc)) return 1;
    return 0;
  endfunction

  task automatic model_bubble();
    {m_rs, m_rt, m_rd, m_esc, m_lee, m_ctrl, m_a, m_b, m_inm} = '0;
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".Rs"}, 64'(Rs), 64'(m_rs));
    chk({tag, ".Rt"}, 64'(Rt), 64'(m_rt));
    chk({tag, ".RdEx"}, 64'(RdEx), 64'(m_rd));
    chk({tag, ".EscMemEx"}, 64'(EscMemEx), 64'(m_esc));
    chk({tag, ".LeeMemEx"}, 64'(LeeMemEx), 64'(m_lee));
    chk({tag, ".CtrlEx"}, 64'(CtrlEx), 64'(m_ctrl));
    chk({tag, ".A_Ex"}, 64'(A_Ex), 64'(m_a));
    chk({tag, ".B_Ex"}, 64'(B_Ex), 64'(m_b));
    chk({tag, ".Inm_Ex"}, 64'(Inm_Ex), 64'(m_inm));
  endtask

  // Called just after a falling edge with ID inputs already driven.
  task automatic cycle(input string tag);
    int n;
    bit stall;
    #1;
    n = stalls_needed();
    stall = (m_left > 0) || (n > 0);
    chk({tag, ".detener"}, 64'(detener), 64'(stall));
    @(posedge clk);
    if (limpiar) begin
      model_bubble();
      m_left = 0;
    end else if (!congelar) begin
      if (stall) begin
        model_bubble();
        m_left = (m_left == 0) ? n - 1 : m_left - 1;
      end else begin
        m_rs = RsD; m_rt = RtD; m_rd = RdD; m_esc = EscRegD; m_lee = LeeMemD;
        m_ctrl = CtrlD; m_a = A_D; m_b = B_D; m_inm = Inm_D;
      end
    end
    #1;
    check_outs(tag);
    @(negedge clk);
  endtask

  task automatic id_instr(input int rs, input int rt, input int rd, input bit urs, input bit urt,
                          input bit esc, input bit lee, input bit br);
    RsD = AR'(rs); RtD = AR'(rt); RdD = AR'(rd); UsaRsD = urs; UsaRtD = urt;
    EscRegD = esc; LeeMemD = lee; EsBranchD = br;
    CtrlD = AC'($urandom); A_D = $urandom; B_D = $urandom; Inm_D = $urandom;
  endtask

  initial begin
    congelar = 0; limpiar = 0; RdMem = 0; EscMem = 0;
    // Branch hazard on the MEM inputs while reset is held: detener must stay low.
    id_instr(3, 0, 0, 1, 0, 0, 0, 1);
    RdMem = 3; EscMem = 1;
    model_bubble(); m_left = 0;
    #3;
    chk("reset.detener", 64'(detener), 64'd0);
    check_outs("reset");
    @(negedge clk); @(negedge clk);
    RdMem = 0; EscMem = 0;
    rst_n = 1;

    id_instr(3, 0, 5, 1, 0, 1, 0, 0);
    cycle("basic");
    chk("basic.Rs3", 64'(Rs), 64'd3);
    chk("basic.Rd5", 64'(RdEx), 64'd5);

    id_instr(1, 2, 8, 1, 0, 1, 1, 0);
    cycle("ld8");
    id_instr(8, 2, 9, 1, 0, 1, 0, 0);
    cycle("use.stall");
    chk("use.bubble", 64'(RdEx), 64'd0);
    cycle("use.go");
    chk("use.enter", 64'(RdEx), 64'd9);

    id_instr(1, 2, 4, 1, 0, 1, 1, 0);
    cycle("ld4");
    id_instr(1, 4, 0, 0, 1, 0, 0, 1);
    cycle("br2.s1");
    chk("br2.s1det", 64'(detener), 64'd1);
    cycle("br2.s2");
    cycle("br2.go");

    id_instr(6, 0, 0, 1, 0, 0, 0, 1);
    RdMem = 6; EscMem = 1;
    cycle("brmem.s1");
    cycle("brmem.go");
    RdMem = 0; EscMem = 0;
    id_instr(1, 2, 6, 1, 0, 1, 0, 0);
    cycle("alu6");
    id_instr(6, 0, 0, 1, 0, 0, 0, 1);
    cycle("bralu.nostall");

    id_instr(1, 2, 0, 1, 0, 1, 1, 0);
    cycle("ld0");
    id_instr(0, 0, 3, 1, 0, 1, 0, 0);
    cycle("rd0.nostall");
    id_instr(1, 2, 7, 1, 0, 1, 1, 0);
    cycle("ld7");
    id_instr(7, 7, 3, 0, 0, 1, 0, 0);
    cycle("nouse.nostall");

    id_instr(1, 2, 4, 1, 0, 1, 1, 0);
    cycle("ld4b");
    id_instr(1, 4, 0, 0, 1, 0, 0, 1);
    cycle("frz.s1");
    congelar = 1;
    for (int i = 0; i < 3; i++) cycle("frz.hold");
    limpiar = 1;
    cycle("flush");
    congelar = 0; limpiar = 0;
    cycle("flush.reeval");

    id_instr(1, 2, 4, 1, 0, 1, 1, 0);
    cycle("ld4c");
    id_instr(1, 4, 0, 0, 1, 0, 0, 1);
    cycle("rst.s1");
    #2 rst_n = 0;
    #1;
    model_bubble(); m_left = 0;
    chk("rst.detener", 64'(detener), 64'd0);
    check_outs("rst.async");
    @(negedge clk);
    rst_n = 1;
    id_instr(1, 2, 3, 1, 1, 1, 0, 0);
    cycle("rst.after");

    for (int k = 0; k < 400; k++) begin
      id_instr($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
               $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
               $urandom_range(0, 1), ($urandom_range(0, 3) == 0));
      RdMem = AR'($urandom_range(0, 7));
      EscMem = $urandom_range(0, 1);
      congelar = ($urandom_range(0, 7) == 0);
      limpiar = ($urandom_range(0, 9) == 0);
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
